// File: rtl/hamming_decode_arbiter_if.sv
// hamming_decode_arbiter_if: requester, decoder and result signals
// for the shared serial Hamming(7,4) decoder arbiter.
interface hamming_decode_arbiter_if #(
  parameter int NUM_CH = 4
);
  localparam int CHW = $clog2(NUM_CH);

  logic [NUM_CH-1:0]   req;
  logic [7*NUM_CH-1:0] code_in;
  logic [NUM_CH-1:0]   gnt;
  logic                dec_ena;
  logic                dec_bit;
  logic                dec_valid;
  logic [3:0]          dec_data;
  logic [2:0]          dec_syndrome;
  logic                res_valid;
  logic                res_ready;
  logic [CHW-1:0]      res_ch;
  logic [3:0]          res_data;
  logic [2:0]          res_syndrome;
  logic                res_timeout;
  logic                busy;
  logic [7:0]          err_count;

  modport master (
    input  req, code_in,
    input  dec_valid, dec_data, dec_syndrome,
    input  res_ready,
    output gnt, dec_ena, dec_bit,
    output res_valid, res_ch, res_data,
    output res_syndrome, res_timeout,
    output busy, err_count
  );

  modport slave (
    output req, code_in,
    output dec_valid, dec_data, dec_syndrome,
    output res_ready,
    input  gnt, dec_ena, dec_bit,
    input  res_valid, res_ch, res_data,
    input  res_syndrome, res_timeout,
    input  busy, err_count
  );
endinterface

// File: rtl/hamming_decode_arbiter.sv
// hamming_decode_arbiter: round-robin share of one serial Hamming(7,4) decoder.
// Define HAMMING_ERR_CNT_EN to enable the saturating corrected-error counter.
module hamming_decode_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  hamming_decode_arbiter_if.master bus
);
  localparam int CHW = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT,
    OUT
  } state_t;

  state_t            state;
  logic [CHW-1:0]    ptr;
  logic [6:0]        code_q;
  logic [3:0]        bcnt;
  logic [3:0]        wcnt;
  logic              pick_vld;
  logic [CHW-1:0]    pick_ch;
  logic [CHW-1:0]    idx;
  logic [NUM_CH-1:0] pick_oh;
  logic [6:0]        pick_code;
  logic              take;

  // first requester at or after ptr+1, wrapping
  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = '0;
    idx      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CHW'((int'(ptr) + i) % NUM_CH);
      if (!pick_vld && bus.req[idx]) begin
        pick_vld = 1'b1;
        pick_ch  = idx;
      end
    end
  end

  always_comb begin
    pick_code = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (CHW'(c) == pick_ch) begin
        pick_code = bus.code_in[7*c +: 7];
      end
    end
  end

  assign pick_oh = pick_vld ?
    (NUM_CH'(1) << pick_ch) : '0;

  // a grant can follow an OUT handshake directly
  assign take = pick_vld &&
    ((state == IDLE) ||
     (state == OUT && bus.res_ready));

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      ptr              <= CHW'(NUM_CH - 1);
      code_q           <= '0;
      bcnt             <= '0;
      wcnt             <= '0;
      bus.gnt          <= '0;
      bus.dec_ena      <= 1'b0;
      bus.dec_bit      <= 1'b0;
      bus.res_valid    <= 1'b0;
      bus.res_ch       <= '0;
      bus.res_data     <= '0;
      bus.res_syndrome <= '0;
      bus.res_timeout  <= 1'b0;
    end else begin
      bus.gnt <= '0;
      unique case (state)
        IDLE: begin
        end
        SHIFT: begin
          bcnt <= bcnt + 4'd1;
          if (bcnt == 4'd8) begin
            bus.dec_ena <= 1'b0;
            bus.dec_bit <= 1'b0;
            wcnt        <= '0;
            state       <= WAIT;
          end else begin
            bus.dec_ena <= 1'b1;
            bus.dec_bit <= (bcnt < 4'd7) ?
              code_q[bcnt[2:0]] : 1'b0;
          end
        end
        WAIT: begin
          if (bus.dec_valid) begin
            bus.res_valid    <= 1'b1;
            bus.res_ch       <= ptr;
            bus.res_data     <= bus.dec_data;
            bus.res_syndrome <= bus.dec_syndrome;
            bus.res_timeout  <= 1'b0;
            state            <= OUT;
          end else if (wcnt == 4'(TIMEOUT_CYCLES)) begin
            bus.res_valid    <= 1'b1;
            bus.res_ch       <= ptr;
            bus.res_data     <= '0;
            bus.res_syndrome <= '0;
            bus.res_timeout  <= 1'b1;
            state            <= OUT;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        OUT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            if (!pick_vld) begin
              state <= IDLE;
            end
          end
        end
      endcase
      if (take) begin
        bus.gnt <= pick_oh;
        code_q  <= pick_code;
        ptr     <= pick_ch;
        bcnt    <= '0;
        state   <= SHIFT;
      end
    end
  end

`ifdef HAMMING_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (state == WAIT &&
                 bus.dec_valid &&
                 bus.dec_syndrome != 3'd0 &&
                 err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign bus.err_count = err_q;
`else
  assign bus.err_count = 8'h00;
`endif

endmodule

// File: tb/tb_hamming_decode_arbiter.sv
// tb_hamming_decode_arbiter: directed checks of grant order, serial timing,
// timeout, back-pressure and the optional error counter.
module tb_hamming_decode_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  bit   mute = 1'b0;

  localparam logic [6:0] C0 = 7'b0000000;
  localparam logic [6:0] C1 = 7'b1010101;
  localparam logic [6:0] C2 = 7'b1111111;
  localparam logic [6:0] C3 = 7'b1000101;

  hamming_decode_arbiter_if #(.NUM_CH(4)) bus();

  hamming_decode_arbiter #(
    .NUM_CH(4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // serial decoder: positions 1..7 = bits 0..6, syndrome = error position
  function automatic logic [6:0] hdec(input logic [6:0] c);
    logic [2:0] s;
    logic [6:0] f;
    s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
    s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
    s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
    f = c;
    if (s != 3'd0) f[s - 3'd1] = ~f[s - 3'd1];
    return {f[6], f[5], f[4], f[2], s};
  endfunction

  logic [2:0] mcnt;
  logic [6:0] msr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= '0;
      msr <= '0;
      bus.dec_valid <= 1'b0;
      bus.dec_data <= '0;
      bus.dec_syndrome <= '0;
    end else begin
      bus.dec_valid <= 1'b0;
      if (bus.dec_ena) begin
        mcnt <= mcnt + 3'd1;
        if (mcnt < 3'd7) msr[mcnt] <= bus.dec_bit;
        if (mcnt == 3'd7 && !mute) begin
          bus.dec_valid <= 1'b1;
          {bus.dec_data, bus.dec_syndrome} <= hdec(msr);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output bit ok, output int t);
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (bus.gnt != '0) begin
        ok = 1'b1;
        t = cyc;
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.res_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    bit ok;
    int t;
    int seen;
    logic [31:0] outs;
    tick(2);
    outs = {bus.gnt, bus.dec_ena, bus.dec_bit, bus.res_valid,
            bus.res_ch, bus.res_data, bus.res_syndrome,
            bus.res_timeout, bus.busy, bus.err_count};
    nvec++;
    if (outs !== '0) begin
      nerr++;
      $display("FAIL reset_init: got %h want 0", outs);
    end
    rst_n = 1'b1;
    tick(1);
    bus.req = 4'b0001;
    wait_gnt(ok, t);
    nvec++;
    if (ok !== 1'b1) begin
      nerr++;
      $display("FAIL reset_gnt: got %b want 1", ok);
    end
    tick(3);
    nvec++;
    if ({bus.dec_ena, bus.busy} !== 2'b11) begin
      nerr++;
      $display("FAIL reset_shift: got %b want 11", {bus.dec_ena, bus.busy});
    end
    #2 rst_n = 1'b0;
    #1;
    outs = {bus.gnt, bus.dec_ena, bus.dec_bit, bus.res_valid,
            bus.res_ch, bus.res_data, bus.res_syndrome,
            bus.res_timeout, bus.busy, bus.err_count};
    nvec++;
    if (outs !== '0) begin
      nerr++;
      $display("FAIL reset_async: got %h want 0", outs);
    end
    tick(1);
    outs = {bus.gnt, bus.dec_ena, bus.dec_bit, bus.res_valid,
            bus.res_ch, bus.res_data, bus.res_syndrome,
            bus.res_timeout, bus.busy, bus.err_count};
    nvec++;
    if (outs !== '0) begin
      nerr++;
      $display("FAIL reset_next: got %h want 0", outs);
    end
    bus.req = '0;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.res_valid !== 1'b0 || bus.gnt !== '0) seen++;
    end
    nvec++;
    if (seen !== 0) begin
      nerr++;
      $display("FAIL reset_quiet: got %0d want 0", seen);
    end
  endtask

  task automatic test_single();
    bit ok;
    int t;
    logic [7:0] eb;
    eb = {1'b0, C1};
    bus.req = 4'b0010;
    wait_gnt(ok, t);
    bus.req = '0;
    nvec++;
    if (bus.gnt !== 4'b0010) begin
      nerr++;
      $display("FAIL single_gnt: got %b want 0010", bus.gnt);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1);
      nvec++;
      if ({bus.dec_ena, bus.dec_bit} !== {1'b1, eb[i]}) begin
        nerr++;
        $display("FAIL single_bit%0d: got %b want %b",
                 i, {bus.dec_ena, bus.dec_bit}, {1'b1, eb[i]});
      end
    end
    tick(1);
    nvec++;
    if ({bus.dec_ena, bus.res_valid} !== 2'b00) begin
      nerr++;
      $display("FAIL single_t9: got %b want 00", {bus.dec_ena, bus.res_valid});
    end
    tick(1);
    nvec++;
    if ({bus.res_valid, bus.res_ch, bus.res_data, bus.res_syndrome,
         bus.res_timeout} !== {1'b1, 2'd1, 4'hB, 3'd0, 1'b0}) begin
      nerr++;
      $display("FAIL single_res: got %b_%0d_%h_%b_%b want 1_1_b_000_0",
               bus.res_valid, bus.res_ch, bus.res_data,
               bus.res_syndrome, bus.res_timeout);
    end
    nvec++;
    if (cyc - t !== 10) begin
      nerr++;
      $display("FAIL single_latency: got %0d want 10", cyc - t);
    end
    tick(1);
    nvec++;
    if (bus.res_valid !== 1'b0) begin
      nerr++;
      $display("FAIL single_drop: got %b want 0", bus.res_valid);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int t;
    int tprev;
    int ch;
    logic [3:0] eg;
    logic [3:0] ed [4];
    logic [2:0] es [4];
    ed = '{4'h0, 4'hB, 4'hF, 4'hB};
    es = '{3'd0, 3'd0, 3'd0, 3'd5};
    tprev = 0;
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      ch = k % 4;
      eg = 4'(1) << ch;
      wait_gnt(ok, t);
      nvec++;
      if (bus.gnt !== eg) begin
        nerr++;
        $display("FAIL rr_gnt%0d: got %b want %b", k, bus.gnt, eg);
      end
      if (k > 0) begin
        nvec++;
        if (t - tprev !== 11) begin
          nerr++;
          $display("FAIL rr_gap%0d: got %0d want 11", k, t - tprev);
        end
      end
      tprev = t;
      if (k == 4) bus.req = '0;
      tick(10);
      nvec++;
      if ({bus.res_valid, bus.res_ch, bus.res_data, bus.res_syndrome,
           bus.res_timeout} !== {1'b1, 2'(ch), ed[ch], es[ch], 1'b0}) begin
        nerr++;
        $display("FAIL rr_res%0d: got %b_%0d_%h_%b want 1_%0d_%h_%b",
                 k, bus.res_valid, bus.res_ch, bus.res_data,
                 bus.res_syndrome, ch, ed[ch], es[ch]);
      end
    end
    tick(1);
  endtask

  task automatic test_timeout();
    bit ok;
    int t;
    mute = 1'b1;
    bus.req = 4'b0100;
    wait_gnt(ok, t);
    bus.req = '0;
    nvec++;
    if (bus.gnt !== 4'b0100) begin
      nerr++;
      $display("FAIL to_gnt: got %b want 0100", bus.gnt);
    end
    tick(13);
    nvec++;
    if (bus.res_valid !== 1'b0) begin
      nerr++;
      $display("FAIL to_early: got %b want 0", bus.res_valid);
    end
    tick(1);
    nvec++;
    if ({bus.res_valid, bus.res_ch, bus.res_data, bus.res_syndrome,
         bus.res_timeout} !== {1'b1, 2'd2, 4'h0, 3'd0, 1'b1}) begin
      nerr++;
      $display("FAIL to_res: got %b_%0d_%h_%b_%b want 1_2_0_000_1",
               bus.res_valid, bus.res_ch, bus.res_data,
               bus.res_syndrome, bus.res_timeout);
    end
    nvec++;
    if (cyc - t !== 14) begin
      nerr++;
      $display("FAIL to_latency: got %0d want 14", cyc - t);
    end
    mute = 1'b0;
    tick(1);
  endtask

  task automatic test_back_pressure();
    bit ok;
    int t;
    int bad;
    logic [10:0] snap;
    bus.res_ready = 1'b0;
    bus.req = 4'b0001;
    wait_gnt(ok, t);
    tick(10);
    snap = {bus.res_valid, bus.res_ch, bus.res_data,
            bus.res_syndrome, bus.res_timeout};
    nvec++;
    if (snap !== {1'b1, 2'd0, 4'h0, 3'd0, 1'b0}) begin
      nerr++;
      $display("FAIL bp_res: got %b want 10000000000", snap);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if ({bus.res_valid, bus.res_ch, bus.res_data, bus.res_syndrome,
           bus.res_timeout} !== snap || bus.gnt !== '0) bad++;
    end
    nvec++;
    if (bad !== 0) begin
      nerr++;
      $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
    end
    bus.res_ready = 1'b1;
    tick(1);
    nvec++;
    if ({bus.gnt, bus.res_valid} !== 5'b00010) begin
      nerr++;
      $display("FAIL bp_regrant: got %b want 00010", {bus.gnt, bus.res_valid});
    end
    bus.req = '0;
    tick(10);
    nvec++;
    if ({bus.res_valid, bus.res_ch} !== 3'b100) begin
      nerr++;
      $display("FAIL bp_next: got %b want 100", {bus.res_valid, bus.res_ch});
    end
    tick(1);
  endtask

  task automatic run_n(input logic [3:0] r, input int n);
    bit ok;
    int t;
    bus.req = r;
    for (int i = 0; i < n; i++) begin
      wait_gnt(ok, t);
      nvec++;
      if (ok !== 1'b1) begin
        nerr++;
        $display("FAIL run_gnt: got %b want 1", ok);
        bus.req = '0;
        return;
      end
    end
    bus.req = '0;
    tick(12);
  endtask

  task automatic test_err_count();
`ifdef HAMMING_ERR_CNT_EN
    do_reset();
    run_n(4'b1000, 3);
    run_n(4'b0001, 1);
    nvec++;
    if (bus.err_count !== 8'd3) begin
      nerr++;
      $display("FAIL err_three: got %0d want 3", bus.err_count);
    end
    run_n(4'b1000, 300);
    nvec++;
    if (bus.err_count !== 8'hFF) begin
      nerr++;
      $display("FAIL err_sat: got %h want ff", bus.err_count);
    end
`else
    run_n(4'b1000, 2);
    nvec++;
    if (bus.err_count !== 8'h00) begin
      nerr++;
      $display("FAIL err_tied: got %h want 00", bus.err_count);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.req = '0;
    bus.code_in = {C3, C2, C1, C0};
    bus.res_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_back_pressure();
    test_err_count();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
